gate_truth_checker: RTL and testbench

GATE_TRUTH_CHECKER -- requirements
Module: gate_truth_checker

---
 rtl/gate_chk_pkg.sv | 30 +++
 rtl/gate_ref_model.sv | 27 ++
 rtl/gate_truth_checker.sv | 134 +++++++++++++
 tb/tb_gate_truth_checker.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/gate_chk_pkg.sv
// Shared definitions for the gate truth-table checker: gate encodings,
// FSM state encoding and the sweep geometry.
package gate_chk_pkg;

  typedef enum logic [2:0] {
    GATE_AND  = 3'd0,
    GATE_OR   = 3'd1,
    GATE_NAND = 3'd2,
    GATE_NOR  = 3'd3,
    GATE_XOR  = 3'd4,
    GATE_XNOR = 3'd5,
    GATE_NOTA = 3'd6,
    GATE_BUFA = 3'd7
  } gate_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  localparam int NUM_VECTORS = 4;
  localparam int VEC_W       = 2;
  localparam int CNT_W       = 4;
  localparam int ERR_W       = 3;

  localparam logic [VEC_W-1:0] LAST_IDX = VEC_W'(NUM_VECTORS - 1);

endpackage

// File: rtl/gate_ref_model.sv
// Combinational reference for the gate under test; gives the expected
// output for the selected gate type at the applied a,b.
module gate_ref_model
  import gate_chk_pkg::*;
(
  input  logic [2:0] sel,
  input  logic       a,
  input  logic       b,
  output logic       y
);

  always_comb begin
    y = 1'b0;
    case (sel)
      GATE_AND:  y = a & b;
      GATE_OR:   y = a | b;
      GATE_NAND: y = ~(a & b);
      GATE_NOR:  y = ~(a | b);
      GATE_XOR:  y = a ^ b;
      GATE_XNOR: y = ~(a ^ b);
      GATE_NOTA: y = ~a;
      GATE_BUFA: y = a;
      default:   y = 1'b0;
    endcase
  end

endmodule

// File: rtl/gate_truth_checker.sv
// Sweeps vectors 00,01,10,11 into a 2-input gate, waits SETTLE_CYCLES per
// vector, samples its output and accumulates mismatch results.
//
//   state  | meaning
//   IDLE   | waiting for start; results of the last sweep are held
//   SETTLE | stimulus applied, settle down-counter running
//   SAMPLE | compare dut_out with the reference, then next vector or DONE
//   DONE   | one-cycle done pulse, pass valid
module gate_truth_checker
  import gate_chk_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       gate_sel,
  input  logic             dut_out,
  output logic             a,
  output logic             b,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [3:0]       fail_mask
);

  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES);

  state_e           state_q, state_d;
  logic [VEC_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       sel_q, sel_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic [3:0]       mask_q, mask_d;
  logic             pass_q, pass_d;
  logic             expected;
  logic             mismatch;

  gate_ref_model u_ref (
    .sel (sel_q),
    .a   (idx_q[1]),
    .b   (idx_q[0]),
    .y   (expected)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      sel_q   <= '0;
      err_q   <= '0;
      mask_q  <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      err_q   <= err_d;
      mask_q  <= mask_d;
      pass_q  <= pass_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    sel_d    = sel_q;
    err_d    = err_q;
    mask_d   = mask_q;
    pass_d   = pass_q;
    mismatch = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          sel_d   = gate_sel;
          err_d   = '0;
          mask_d  = '0;
          pass_d  = 1'b0;
          idx_d   = '0;
          cnt_d   = SETTLE_LOAD;
          state_d = ST_SETTLE;
        end
      end

      ST_SETTLE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end
        if (cnt_q <= CNT_W'(1)) begin
          state_d = ST_SAMPLE;
        end
      end

      ST_SAMPLE: begin
        mismatch = (dut_out != expected);
        if (mismatch) begin
          mask_d[idx_q] = 1'b1;
          err_d         = err_q + ERR_W'(1);
        end
        // pass is resolved here so it is already valid while done is high
        if (idx_q == LAST_IDX) begin
          pass_d  = (err_d == '0);
          state_d = ST_DONE;
        end else begin
          idx_d   = idx_q + VEC_W'(1);
          cnt_d   = SETTLE_LOAD;
          state_d = ST_SETTLE;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign a         = idx_q[1];
  assign b         = idx_q[0];
  assign busy      = (state_q == ST_SETTLE) || (state_q == ST_SAMPLE);
  assign done      = (state_q == ST_DONE);
  assign pass      = pass_q;
  assign err_count = err_q;
  assign fail_mask = mask_q;

endmodule

// File: tb/tb_gate_truth_checker.sv
// Bench for gate_truth_checker: two instances (settle 2 and settle 1) driving
// a behavioural gate; expected sweep results are queued and checked on done.
module tb_gate_truth_checker;

  typedef struct packed {
    logic [3:0] mask;
    logic [2:0] err;
    logic       pass;
  } exp_t;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic       start0 = 1'b0, start1 = 1'b0;
  logic [2:0] gate_sel0 = 3'd0, gate_sel1 = 3'd0;
  logic [2:0] gut0 = 3'd0, gut1 = 3'd0;
  logic       dut_out0, dut_out1;
  logic       a0, b0, busy0, done0, pass0;
  logic       a1, b1, busy1, done1, pass1;
  logic [2:0] err0, err1;
  logic [3:0] mask0, mask1;

  // truth tables, bit i = output for a=i[1], b=i[0]; indexed by gate code
  logic [3:0] tt [8] = '{4'b1000, 4'b1110, 4'b0111, 4'b0001,
                         4'b0110, 4'b1001, 4'b0011, 4'b1100};

  int   tests  = 0;
  int   failed = 0;
  exp_t sb[$];
  logic unit = 1'b0;

  logic       a_o, b_o, busy_o, done_o, pass_o;
  logic [2:0] err_o;
  logic [3:0] mask_o;

  always #5 clk = ~clk;

  assign dut_out0 = tt[gut0][{a0, b0}];
  assign dut_out1 = tt[gut1][{a1, b1}];

  assign a_o    = unit ? a1    : a0;
  assign b_o    = unit ? b1    : b0;
  assign busy_o = unit ? busy1 : busy0;
  assign done_o = unit ? done1 : done0;
  assign pass_o = unit ? pass1 : pass0;
  assign err_o  = unit ? err1  : err0;
  assign mask_o = unit ? mask1 : mask0;

  gate_truth_checker #(.SETTLE_CYCLES(2)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .gate_sel(gate_sel0),
    .dut_out(dut_out0), .a(a0), .b(b0), .busy(busy0), .done(done0),
    .pass(pass0), .err_count(err0), .fail_mask(mask0)
  );

  gate_truth_checker #(.SETTLE_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .gate_sel(gate_sel1),
    .dut_out(dut_out1), .a(a1), .b(b1), .busy(busy1), .done(done1),
    .pass(pass1), .err_count(err1), .fail_mask(mask1)
  );

  task automatic drive(input logic u, input logic st, input logic [2:0] sel);
    if (u) begin
      start1 = st; gate_sel1 = sel;
    end else begin
      start0 = st; gate_sel0 = sel;
    end
  endtask

  // k counts negedges after the accepting edge; done is seen at k = 4*(S+1)
  task automatic run_sweep(input logic u, input logic [2:0] sel, input logic [2:0] gut,
                           input logic disturb, input logic hold, input string name);
    int s, len, kmax, kk, nv;
    exp_t e, got;
    logic [3:0] exp_vec, part;
    s    = u ? 1 : 2;
    len  = 4 * (s + 1);
    kmax = hold ? 2 * len + 4 : len + 2;
    unit = u;
    if (u) gut1 = gut; else gut0 = gut;
    e.mask = tt[sel] ^ tt[gut];
    e.err  = 3'($countones(e.mask));
    e.pass = (e.mask == 4'd0);
    @(negedge clk);
    drive(u, 1'b1, sel);
    @(posedge clk);
    sb.push_back(e);
    for (int k = 0; k <= kmax; k++) begin
      @(negedge clk);
      kk = (hold && k >= len + 2) ? k - (len + 2) : k;
      if (kk < len)       exp_vec = {2'(kk / (s + 1)), 2'b10};
      else if (kk == len) exp_vec = 4'b1101;
      else                exp_vec = 4'b1100;
      tests++;
      if ({a_o, b_o, busy_o, done_o} !== exp_vec) begin
        failed++;
        $display("FAIL %s ab_busy_done k=%0d got=%b want=%b", name, k,
                 {a_o, b_o, busy_o, done_o}, exp_vec);
      end
      if (kk < len) begin
        nv   = kk / (s + 1);
        part = e.mask & 4'((1 << nv) - 1);
        tests++;
        if ({pass_o, err_o, mask_o} !== {1'b0, 3'($countones(part)), part}) begin
          failed++;
          $display("FAIL %s partial k=%0d got=%b/%0d/%b want=0/%0d/%b", name, k,
                   pass_o, err_o, mask_o, $countones(part), part);
        end
      end else if (kk > len) begin
        tests++;
        if ({pass_o, err_o, mask_o} !== {e.pass, e.err, e.mask}) begin
          failed++;
          $display("FAIL %s held k=%0d got=%b/%0d/%b want=%b/%0d/%b", name, k,
                   pass_o, err_o, mask_o, e.pass, e.err, e.mask);
        end
      end
      if (done_o) begin
        tests++;
        if (sb.size() == 0) begin
          failed++;
          $display("FAIL %s unexpected_done k=%0d got=done want=no_done", name, k);
        end else begin
          got = sb.pop_front();
          if ({pass_o, err_o, mask_o} !== {got.pass, got.err, got.mask}) begin
            failed++;
            $display("FAIL %s result got=%b/%0d/%b want=%b/%0d/%b", name,
                     pass_o, err_o, mask_o, got.pass, got.err, got.mask);
          end
        end
      end
      if (!hold && k == 0)        drive(u, 1'b0, sel);
      if (hold && k == len + 1)   sb.push_back(e);
      if (hold && k == len + 2)   drive(u, 1'b0, sel);
      if (disturb && k == s + 1)  drive(u, 1'b1, ~sel);
      if (disturb && k == s + 2)  drive(u, 1'b0, sel ^ 3'd1);
    end
    tests++;
    if (sb.size() != 0) begin
      failed++;
      $display("FAIL %s pending got=%0d want=0", name, sb.size());
    end
    sb.delete();
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #2;
    for (int r = 0; r < 2; r++) begin
      tests++;
      if ({a0, b0, busy0, done0, pass0, err0, mask0} !== 12'd0) begin
        failed++;
        $display("FAIL reset0 r=%0d got=%b want=0", r, {a0, b0, busy0, done0, pass0, err0, mask0});
      end
      tests++;
      if ({a1, b1, busy1, done1, pass1, err1, mask1} !== 12'd0) begin
        failed++;
        $display("FAIL reset1 r=%0d got=%b want=0", r, {a1, b1, busy1, done1, pass1, err1, mask1});
      end
      repeat (2) @(negedge clk);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_basic_gates();
    run_sweep(1'b0, 3'd2, 3'd2, 1'b0, 1'b0, "nand_pass");
    run_sweep(1'b0, 3'd0, 3'd2, 1'b0, 1'b0, "and_vs_nand");
    run_sweep(1'b0, 3'd4, 3'd1, 1'b0, 1'b0, "xor_vs_or");
  endtask

  task automatic test_other_gates();
    logic [2:0] sels [4] = '{3'd3, 3'd6, 3'd5, 3'd7};
    logic [2:0] guts [4] = '{3'd3, 3'd7, 3'd5, 3'd1};
    for (int i = 0; i < 4; i++)
      run_sweep(1'b0, sels[i], guts[i], 1'b0, 1'b0, $sformatf("gates%0d", i));
  endtask

  task automatic test_start_ignored();
    run_sweep(1'b0, 3'd1, 3'd1, 1'b1, 1'b0, "start_ignored");
  endtask

  task automatic test_reset_mid_sweep();
    exp_t e;
    unit = 1'b0;
    gut0 = 3'd2;
    e.mask = 4'b1111; e.err = 3'd4; e.pass = 1'b0;
    @(negedge clk);
    drive(1'b0, 1'b1, 3'd0);
    @(posedge clk);
    sb.push_back(e);
    @(negedge clk);
    drive(1'b0, 1'b0, 3'd0);
    repeat (8) @(negedge clk);
    tests++;
    if ({a0, b0, busy0, done0, err0, mask0} !== {4'b1010, 3'd2, 4'b0011}) begin
      failed++;
      $display("FAIL pre_reset got=%b want=%b", {a0, b0, busy0, done0, err0, mask0},
               {4'b1010, 3'd2, 4'b0011});
    end
    #1 rst_n = 1'b0;
    #1;
    tests++;
    if ({a0, b0, busy0, done0, pass0, err0, mask0} !== 12'd0) begin
      failed++;
      $display("FAIL async_reset got=%b want=0", {a0, b0, busy0, done0, pass0, err0, mask0});
    end
    sb.delete();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests++;
      if ({a0, b0, busy0, done0, pass0, err0, mask0} !== 12'd0) begin
        failed++;
        $display("FAIL in_reset i=%0d got=%b want=0", i, {a0, b0, busy0, done0, pass0, err0, mask0});
      end
    end
    rst_n = 1'b1;
    run_sweep(1'b0, 3'd2, 3'd2, 1'b0, 1'b0, "after_reset");
  endtask

  task automatic test_back_to_back();
    run_sweep(1'b1, 3'd0, 3'd2, 1'b0, 1'b0, "s1_single");
    run_sweep(1'b1, 3'd2, 3'd2, 1'b0, 1'b1, "s1_held_pass");
    run_sweep(1'b1, 3'd4, 3'd1, 1'b0, 1'b1, "s1_held_xor");
  endtask

  initial begin
    test_reset();
    test_basic_gates();
    test_other_gates();
    test_start_ignored();
    test_reset_mid_sweep();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
